// File: rtl/riscv_imem_arb_pkg.sv
// Shared types and constants for the two-port instruction-memory arbiter.
package riscv_imem_arb_pkg;

  typedef enum logic {
    ARB_FREE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  // Upper bound on MAX_OUTSTANDING; sizes the owner FIFO storage.
  localparam int unsigned MAX_OUTSTANDING_MAX = 4;

endpackage

// File: rtl/riscv_imem_arb_id_fifo.sv
// Owner FIFO: remembers which port each accepted grant belongs to, in grant order.
import riscv_imem_arb_pkg::*;

module riscv_imem_arb_id_fifo #(
  parameter int unsigned DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       push_id,
  input  logic       pop,
  output logic       pop_id,
  output logic       full,
  output logic       empty,
  output logic [2:0] count
);

  localparam logic [1:0] LAST    = 2'(DEPTH - 1);
  localparam logic [2:0] DEPTH_C = 3'(DEPTH);

  logic [MAX_OUTSTANDING_MAX-1:0] mem;
  logic [1:0] wr_ptr;
  logic [1:0] rd_ptr;
  logic       push_ok;
  logic       pop_ok;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == 3'd0);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign pop_id  = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_id;
        wr_ptr      <= (wr_ptr == LAST) ? 2'd0 : wr_ptr + 2'd1;
      end
      if (pop_ok) begin
        rd_ptr <= (rd_ptr == LAST) ? 2'd0 : rd_ptr + 2'd1;
      end
      if (push_ok && !pop_ok) begin
        count <= count + 3'd1;
      end else if (pop_ok && !push_ok) begin
        count <= count - 3'd1;
      end
    end
  end

endmodule

// File: rtl/riscv_imem_arbiter.sv
// Round-robin arbiter sharing one instruction-memory port between the prefetch
// buffer (port 0) and a secondary requester (port 1).
import riscv_imem_arb_pkg::*;

module riscv_imem_arbiter #(
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p0_req_i,
  input  logic [31:0] p0_addr_i,
  output logic        p0_gnt_o,
  output logic        p0_rvalid_o,
  output logic [31:0] p0_rdata_o,
  input  logic        p1_req_i,
  input  logic [31:0] p1_addr_i,
  output logic        p1_gnt_o,
  output logic        p1_rvalid_o,
  output logic [31:0] p1_rdata_o,
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic [31:0] instr_rdata_i,
  input  logic        instr_rvalid_i,
  output logic        busy_o,
  output logic        err_o
);

  arb_state_e state;
  logic       rr;
  logic       lock_port;
  logic       sel;
  logic       sel_req;
  logic       accept;
  logic       pop;
  logic       head_id;
  logic       full;
  logic       empty;
  logic [2:0] count;

  always_comb begin
    if (state == ARB_LOCKED) begin
      sel = lock_port;
    end else if (p0_req_i && p1_req_i) begin
      sel = rr;
    end else if (p1_req_i) begin
      sel = PORT1;
    end else begin
      sel = PORT0;
    end
  end

  // Full blocks on the registered count only, so rvalid never reaches instr_req_o.
  assign sel_req      = (sel == PORT1) ? p1_req_i : p0_req_i;
  assign instr_req_o  = sel_req && !full;
  assign instr_addr_o = (sel == PORT1) ? p1_addr_i : p0_addr_i;
  assign accept       = instr_req_o && instr_gnt_i;
  assign p0_gnt_o     = accept && (sel == PORT0);
  assign p1_gnt_o     = accept && (sel == PORT1);

  assign pop          = instr_rvalid_i && !empty;
  assign p0_rvalid_o  = pop && (head_id == PORT0);
  assign p1_rvalid_o  = pop && (head_id == PORT1);
  assign p0_rdata_o   = instr_rdata_i;
  assign p1_rdata_o   = instr_rdata_i;

  assign busy_o = (count != 3'd0) || instr_req_o || (state == ARB_LOCKED);

  riscv_imem_arb_id_fifo #(
    .DEPTH(MAX_OUTSTANDING)
  ) u_owner_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (accept),
    .push_id (sel),
    .pop     (pop),
    .pop_id  (head_id),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ARB_FREE;
      rr        <= PORT0;
      lock_port <= PORT0;
      err_o     <= 1'b0;
    end else begin
      case (state)
        ARB_FREE: begin
          if (instr_req_o && !instr_gnt_i) begin
            state     <= ARB_LOCKED;
            lock_port <= sel;
          end
        end
        ARB_LOCKED: begin
          if (!sel_req || accept) begin
            state <= ARB_FREE;
          end
        end
        default: state <= ARB_FREE;
      endcase
      if (accept) begin
        rr <= ~rr;
      end
      if (instr_rvalid_i && empty) begin
        err_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_riscv_imem_arbiter.sv
// Self-checking bench: per-cycle comparison against a queue-based reference model
// plus directed scenarios with hand-computed expectations.
module tb_riscv_imem_arbiter;

  localparam int unsigned MAXO = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        p0_req = 1'b0, p1_req = 1'b0;
  logic [31:0] p0_addr = '0, p1_addr = '0;
  logic        p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
  logic [31:0] p0_rdata, p1_rdata;
  logic        instr_req;
  logic [31:0] instr_addr;
  logic        instr_gnt = 1'b0, instr_rvalid = 1'b0;
  logic [31:0] instr_rdata = '0;
  logic        busy, err;

  int tests = 0;
  int fails = 0;

  // Reference model state
  bit m_q[$];
  bit m_rr;
  bit m_locked;
  bit m_lport;
  bit m_err;

  riscv_imem_arbiter #(.MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .rst(rst),
    .p0_req_i(p0_req), .p0_addr_i(p0_addr), .p0_gnt_o(p0_gnt),
    .p0_rvalid_o(p0_rvalid), .p0_rdata_o(p0_rdata),
    .p1_req_i(p1_req), .p1_addr_i(p1_addr), .p1_gnt_o(p1_gnt),
    .p1_rvalid_o(p1_rvalid), .p1_rdata_o(p1_rdata),
    .instr_req_o(instr_req), .instr_addr_o(instr_addr), .instr_gnt_i(instr_gnt),
    .instr_rdata_i(instr_rdata), .instr_rvalid_i(instr_rvalid),
    .busy_o(busy), .err_o(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_rr = 1'b0;
    m_locked = 1'b0;
    m_lport = 1'b0;
    m_err = 1'b0;
  endtask

  // One clock cycle: drive inputs, compare DUT against model, advance model.
  task automatic step(input bit r0, input logic [31:0] a0, input bit r1, input logic [31:0] a1,
                      input bit g, input bit rv, input logic [31:0] rd);
    bit sel, sreq, ereq, own_ok, owner, full;
    int cnt;
    @(posedge clk);
    #1;
    p0_req = r0; p0_addr = a0; p1_req = r1; p1_addr = a1;
    instr_gnt = g; instr_rvalid = rv; instr_rdata = rd;
    #1;
    cnt  = m_q.size();
    full = (cnt == MAXO);
    if (m_locked)     sel = m_lport;
    else if (r0 && r1) sel = m_rr;
    else              sel = r1;
    sreq   = sel ? r1 : r0;
    ereq   = sreq && !full;
    own_ok = rv && (cnt > 0);
    owner  = own_ok ? m_q[0] : 1'b0;
    check("instr_req",  32'(instr_req),  32'(ereq));
    check("instr_addr", instr_addr,      sel ? a1 : a0);
    check("p0_gnt",     32'(p0_gnt),     32'(g && ereq && !sel));
    check("p1_gnt",     32'(p1_gnt),     32'(g && ereq && sel));
    check("p0_rvalid",  32'(p0_rvalid),  32'(own_ok && !owner));
    check("p1_rvalid",  32'(p1_rvalid),  32'(own_ok && owner));
    check("p0_rdata",   p0_rdata,        rd);
    check("p1_rdata",   p1_rdata,        rd);
    check("busy",       32'(busy),       32'((cnt != 0) || ereq || m_locked));
    check("err",        32'(err),        32'(m_err));
    if (rv) begin
      if (cnt > 0) void'(m_q.pop_front());
      else         m_err = 1'b1;
    end
    if (ereq && g) begin
      m_q.push_back(sel);
      m_rr = !m_rr;
    end
    if (!m_locked && ereq && !g) begin
      m_locked = 1'b1;
      m_lport  = sel;
    end else if (m_locked && (!sreq || (ereq && g))) begin
      m_locked = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    p0_req = 0; p1_req = 0; instr_gnt = 0; instr_rvalid = 0;
    #1;
    check("rst_instr_req", 32'(instr_req), 32'd0);
    check("rst_gnt",       32'({p0_gnt, p1_gnt}), 32'd0);
    check("rst_rvalid",    32'({p0_rvalid, p1_rvalid}), 32'd0);
    check("rst_busy",      32'(busy), 32'd0);
    check("rst_err",       32'(err), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    do_reset();

    // Alternating grants with both requesting; rvalids routed in grant order.
    step(1, 32'h100, 1, 32'h800, 1, 0, 32'hA0);
    check("rr_c0_p0_gnt", 32'(p0_gnt), 32'd1);
    check("rr_c0_addr",   instr_addr,  32'h100);
    step(1, 32'h100, 1, 32'h800, 1, 1, 32'hA1);
    check("rr_c1_p1_gnt",    32'(p1_gnt),    32'd1);
    check("rr_c1_addr",      instr_addr,     32'h800);
    check("rr_c1_p0_rvalid", 32'(p0_rvalid), 32'd1);
    step(1, 32'h100, 1, 32'h800, 1, 1, 32'hA2);
    check("rr_c2_p0_gnt",    32'(p0_gnt),    32'd1);
    check("rr_c2_p1_rvalid", 32'(p1_rvalid), 32'd1);
    check("rr_c2_busy",      32'(busy),      32'd1);

    // Locked port re-targets its address before grant.
    do_reset();
    step(1, 32'h100, 1, 32'h800, 0, 0, 0);
    check("lock_c0_p1_gnt", 32'(p1_gnt), 32'd0);
    step(1, 32'h100, 1, 32'h800, 0, 0, 0);
    step(1, 32'h200, 1, 32'h800, 0, 0, 0);
    check("lock_c2_addr", instr_addr, 32'h200);
    step(1, 32'h200, 1, 32'h800, 1, 0, 0);
    check("lock_c3_p0_gnt", 32'(p0_gnt), 32'd1);
    check("lock_c3_p1_gnt", 32'(p1_gnt), 32'd0);
    check("lock_c3_addr",   instr_addr,  32'h200);

    // Full blocking: rvalid in cycle N releases req only in N+1.
    do_reset();
    step(1, 32'h40, 0, 0, 1, 0, 0);
    step(1, 32'h44, 0, 0, 1, 0, 0);
    step(1, 32'h48, 0, 0, 1, 0, 0);
    check("full_req_blocked", 32'(instr_req), 32'd0);
    step(1, 32'h48, 0, 0, 1, 1, 32'h11);
    check("full_req_same_cycle", 32'(instr_req), 32'd0);
    check("full_rvalid_p0",      32'(p0_rvalid), 32'd1);
    step(1, 32'h48, 0, 0, 1, 0, 0);
    check("full_req_next_cycle", 32'(instr_req), 32'd1);

    // Spurious rvalid sets a sticky error.
    do_reset();
    step(0, 0, 0, 0, 0, 1, 32'h55);
    check("spur_rvalid", 32'({p0_rvalid, p1_rvalid}), 32'd0);
    step(0, 0, 0, 0, 0, 0, 0);
    check("spur_err", 32'(err), 32'd1);
    repeat (3) step(0, 0, 0, 0, 0, 0, 0);
    check("spur_err_sticky", 32'(err), 32'd1);

    // Reset with two outstanding discards ownership.
    do_reset();
    step(1, 32'h10, 0, 0, 1, 0, 0);
    step(1, 32'h14, 0, 0, 1, 0, 0);
    do_reset();
    step(0, 0, 0, 0, 0, 1, 0);
    check("rst_out_rv0", 32'({p0_rvalid, p1_rvalid}), 32'd0);
    step(0, 0, 0, 0, 0, 1, 0);
    check("rst_out_rv1", 32'({p0_rvalid, p1_rvalid}), 32'd0);
    check("rst_out_err", 32'(err), 32'd1);
    step(1, 32'h20, 1, 32'h30, 1, 0, 0);
    check("rst_out_rr0", 32'(p0_gnt), 32'd1);

    // Randomized traffic with occasional resets.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      step($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 9) < 5, $urandom,
           $urandom_range(0, 1) == 1, $urandom_range(0, 9) < 4, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
